mdu_ctrl: RTL and testbench
===========================

// Module: mdu_ctrl
// PURPOSE
//  Sequences the EXE-stage multiply/divide unit: issues DIV/DIVU to the signed/unsigned divider IPs over their
//  valid/ready handshake, stalls EXE until the quotient/remainder returns, and generates HI/LO write enables/data
//  for DIV(U), MULT(U), MTHI, MTLO. Drains in-flight divides when the pipeline is flushed by an exception.
// PARAMETERS
//  DW      32   operand width; divider result bus is 2*DW (quotient upper half, remainder lower half)
// PORTS
//  clk           in   1     clock; single clock domain
//  reset         in   1     synchronous, active-high reset
//  es_valid      in   1     EXE stage holds a valid instruction
//  es_leave      in   1     EXE instruction moves to MEM this cycle (es_valid & ms_allowin & ~es_stop, made outside)
//  es_ex         in   1     EXE instruction carries an exception; suppresses HI/LO writes
//  flush         in   1     ex_from_ws: pipeline flush this cycle
//  op_div/op_divu/op_mult/op_multu/op_mthi/op_mtlo  in 1 each  decoded op, one-hot or all zero
//  src1,src2     in   DW    forwarded rs/rt values
//  prod          in   2*DW  multiplier product (signed/unsigned chosen outside)
//  div_s_tvalid  out  1     signed divider dividend+divisor tvalid
//  div_s_tready  in   1     signed divider divisor tready
//  div_u_tvalid  out  1     unsigned divider tvalid
//  div_u_tready  in   1     unsigned divider tready
//  div_dividend  out  DW    latched dividend to both IPs
//  div_divisor   out  DW    latched divisor to both IPs
//  div_s_dout_tvalid/div_u_dout_tvalid  in 1  result valid
//  div_s_dout/div_u_dout  in 2*DW   {quotient,remainder}
//  es_stop       out  1     stall EXE
//  hl_we         out  2     {hi_we,lo_we}
//  h_wdata       out  DW    HI write data
//  l_wdata       out  DW    LO write data
// BEHAVIOUR
//  Reset: state=IDLE; all outputs 0; operand/result regs 0.
//  States: IDLE, ISSUE, WAIT, DONE, DRAIN. sel_u register records DIVU vs DIV at issue.
//  IDLE: es_valid & (op_div|op_divu) & ~flush -> latch src1/src2, sel_u; go ISSUE.
//  ISSUE: selected tvalid=1 (other 0), operands from latch. On selected tready -> WAIT (or DRAIN if flush seen
//   this cycle or earlier in ISSUE). tvalid never drops before tready, even on flush.
//  WAIT: selected dout_tvalid -> capture dout into result reg, go DONE; flush -> DRAIN.
//  DONE: hl_we=2'b11 only in the first DONE cycle (unless es_ex or flush); h_wdata=result[DW-1:0] (remainder),
//   l_wdata=result[2DW-1:DW] (quotient). Stay until es_leave or flush -> IDLE.
//  DRAIN: wait selected dout_tvalid, discard, -> IDLE. Never writes HI/LO.
//  es_stop = es_valid & (op_div|op_divu) & (state!=DONE); registered-state only, no path from es_leave.
//  A new DIV arriving during DRAIN stalls until IDLE, then issues normally (min 1 IDLE cycle).
//  MULT/MULTU: hl_we=2'b11, {h,l}=prod, in the es_leave cycle only. MTHI: hl_we=2'b10, h_wdata=src1.
//  MTLO: hl_we=2'b01, l_wdata=src1. All writes gated by es_valid & ~es_ex & ~flush; exactly one write per instr.
//  Simultaneous flush and dout_tvalid in WAIT: result discarded, -> IDLE directly.
//  Reset mid-operation returns to IDLE; divider IP is assumed reset with the core.
//  Divide by zero: no trap; result is whatever the IP returns, written as normal.
// TESTING
//  DIV src1=-7,src2=2, IP latency 20 -> es_stop high until DONE; HI=0xFFFFFFFF, LO=0xFFFFFFFD, hl_we=11 for 1 cycle.
//  DIVU src1=0xFFFFFFFF,src2=0x10, tready low 3 cycles -> div_u_tvalid held 4 cycles, operands stable; LO=0x0FFFFFFF, HI=0xF.
//  DIV in WAIT, flush pulse -> DRAIN, es_stop 0, hl_we never set; next DIV issues only after old dout_tvalid.
//  DONE with ms_allowin low 5 cycles -> hl_we high only first cycle, es_stop 0, IDLE after es_leave.
//  MULT prod=0x00000001_80000000 with es_leave delayed 2 cycles -> single hl_we=11 write; MTHI with es_ex=1 -> hl_we=00.
//  Reset asserted during ISSUE -> next cycle all outputs 0, state IDLE.

Source files
------------

// File: rtl/mdu_ctrl.sv
// EXE-stage multiply/divide sequencer: issues DIV/DIVU to the divider IPs, stalls EXE until the result returns,
// drains divides abandoned by a flush, and produces HI/LO write enables and data for DIV(U)/MULT(U)/MTHI/MTLO.
module mdu_ctrl #(
  parameter int DW = 32
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            es_valid,
  input  logic            es_leave,
  input  logic            es_ex,
  input  logic            flush,
  input  logic            op_div,
  input  logic            op_divu,
  input  logic            op_mult,
  input  logic            op_multu,
  input  logic            op_mthi,
  input  logic            op_mtlo,
  input  logic [DW-1:0]   src1,
  input  logic [DW-1:0]   src2,
  input  logic [2*DW-1:0] prod,
  output logic            div_s_tvalid,
  input  logic            div_s_tready,
  output logic            div_u_tvalid,
  input  logic            div_u_tready,
  output logic [DW-1:0]   div_dividend,
  output logic [DW-1:0]   div_divisor,
  input  logic            div_s_dout_tvalid,
  input  logic            div_u_dout_tvalid,
  input  logic [2*DW-1:0] div_s_dout,
  input  logic [2*DW-1:0] div_u_dout,
  output logic            es_stop,
  output logic [1:0]      hl_we,
  output logic [DW-1:0]   h_wdata,
  output logic [DW-1:0]   l_wdata
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_ISSUE,
    S_WAIT,
    S_DONE,
    S_DRAIN
  } state_t;

  state_t            state;
  state_t            state_nx;
  logic              sel_u;
  logic              flush_seen;
  logic              first_done;
  logic [DW-1:0]     dividend_q;
  logic [DW-1:0]     divisor_q;
  logic [2*DW-1:0]   result_q;

  logic              is_div;
  logic              sel_tready;
  logic              sel_dout_vld;
  logic              wr_ok;
  logic              latch_en;
  logic              capture_en;

  assign is_div       = op_div | op_divu;
  assign sel_tready   = sel_u ? div_u_tready : div_s_tready;
  assign sel_dout_vld = sel_u ? div_u_dout_tvalid : div_s_dout_tvalid;
  assign wr_ok        = es_valid & ~es_ex & ~flush;

  assign div_s_tvalid = (state == S_ISSUE) & ~sel_u;
  assign div_u_tvalid = (state == S_ISSUE) & sel_u;
  assign div_dividend = dividend_q;
  assign div_divisor  = divisor_q;

  // Depends on registered state only, so es_leave (built from es_stop) cannot form a loop.
  assign es_stop = es_valid & is_div & (state != S_DONE);

  always_comb begin
    state_nx   = state;
    latch_en   = 1'b0;
    capture_en = 1'b0;
    case (state)
      S_IDLE: begin
        if (es_valid & is_div & ~flush) begin
          state_nx = S_ISSUE;
          latch_en = 1'b1;
        end
      end
      S_ISSUE: begin
        // The handshake must complete even when flushed; the result is then drained.
        if (sel_tready) begin
          state_nx = (flush | flush_seen) ? S_DRAIN : S_WAIT;
        end
      end
      S_WAIT: begin
        if (sel_dout_vld) begin
          if (flush) begin
            state_nx = S_IDLE;
          end else begin
            state_nx   = S_DONE;
            capture_en = 1'b1;
          end
        end else if (flush) begin
          state_nx = S_DRAIN;
        end
      end
      S_DONE: begin
        if (es_leave | flush) begin
          state_nx = S_IDLE;
        end
      end
      S_DRAIN: begin
        if (sel_dout_vld) begin
          state_nx = S_IDLE;
        end
      end
      default: state_nx = S_IDLE;
    endcase
  end

  always_comb begin
    hl_we   = 2'b00;
    h_wdata = '0;
    l_wdata = '0;
    if (state == S_DONE) begin
      h_wdata = result_q[DW-1:0];
      l_wdata = result_q[2*DW-1:DW];
      if (first_done & wr_ok) begin
        hl_we = 2'b11;
      end
    end else if (es_leave & wr_ok) begin
      if (op_mult | op_multu) begin
        hl_we   = 2'b11;
        h_wdata = prod[2*DW-1:DW];
        l_wdata = prod[DW-1:0];
      end else if (op_mthi) begin
        hl_we   = 2'b10;
        h_wdata = src1;
      end else if (op_mtlo) begin
        hl_we   = 2'b01;
        l_wdata = src1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= S_IDLE;
      sel_u      <= 1'b0;
      flush_seen <= 1'b0;
      first_done <= 1'b0;
      dividend_q <= '0;
      divisor_q  <= '0;
      result_q   <= '0;
    end else begin
      state      <= state_nx;
      first_done <= capture_en;
      // Remember a flush that arrives while the request is still waiting for tready.
      flush_seen <= (state_nx == S_ISSUE) & (flush_seen | flush);
      if (latch_en) begin
        dividend_q <= src1;
        divisor_q  <= src2;
        sel_u      <= op_divu;
      end
      if (capture_en) begin
        result_q <= sel_u ? div_u_dout : div_s_dout;
      end
    end
  end

endmodule

// File: tb/tb_mdu_ctrl.sv
// Bench for mdu_ctrl: behavioural divider IPs plus directed and randomized scenarios against a reference model.
`timescale 1ns/1ps
module tb_mdu_ctrl;
  localparam int DW = 32;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic es_valid = 0, es_leave = 0, es_ex = 0, flush = 0;
  logic op_div = 0, op_divu = 0, op_mult = 0, op_multu = 0, op_mthi = 0, op_mtlo = 0;
  logic [DW-1:0] src1 = '0, src2 = '0;
  logic [2*DW-1:0] prod = '0;
  logic div_s_tvalid, div_u_tvalid;
  logic div_s_tready = 0, div_u_tready = 0;
  logic [DW-1:0] div_dividend, div_divisor;
  logic div_s_dout_tvalid = 0, div_u_dout_tvalid = 0;
  logic [2*DW-1:0] div_s_dout = '0, div_u_dout = '0;
  logic es_stop;
  logic [1:0] hl_we;
  logic [DW-1:0] h_wdata, l_wdata;

  int n_tests = 0;
  int n_fail = 0;

  int ip_lat = 4;
  int ip_rdy = 0;
  int cd = 0;
  int tv_cnt = 0;
  bit pend_u = 0;
  bit ip_overlap_err = 0;
  logic [2*DW-1:0] pend_res = '0;

  always #5 clk = ~clk;

  mdu_ctrl #(.DW(DW)) dut (
    .clk(clk), .reset(reset), .es_valid(es_valid), .es_leave(es_leave), .es_ex(es_ex), .flush(flush),
    .op_div(op_div), .op_divu(op_divu), .op_mult(op_mult), .op_multu(op_multu), .op_mthi(op_mthi),
    .op_mtlo(op_mtlo), .src1(src1), .src2(src2), .prod(prod),
    .div_s_tvalid(div_s_tvalid), .div_s_tready(div_s_tready), .div_u_tvalid(div_u_tvalid),
    .div_u_tready(div_u_tready), .div_dividend(div_dividend), .div_divisor(div_divisor),
    .div_s_dout_tvalid(div_s_dout_tvalid), .div_u_dout_tvalid(div_u_dout_tvalid),
    .div_s_dout(div_s_dout), .div_u_dout(div_u_dout),
    .es_stop(es_stop), .hl_we(hl_we), .h_wdata(h_wdata), .l_wdata(l_wdata)
  );

  // {quotient, remainder}; quotient truncates toward zero, remainder takes the dividend's sign.
  function automatic logic [2*DW-1:0] ref_div(input bit u, input logic [DW-1:0] a, input logic [DW-1:0] b);
    logic [DW-1:0] q, r;
    if (u) begin
      q = a / b;
      r = a % b;
    end else begin
      q = $signed(a) / $signed(b);
      r = $signed(a) % $signed(b);
    end
    return {q, r};
  endfunction

  // Divider IPs: tready after ip_rdy cycles of tvalid, result ip_lat cycles after the handshake.
  always @(negedge clk) begin
    div_s_dout_tvalid = 1'b0;
    div_u_dout_tvalid = 1'b0;
    if (reset) begin
      cd = 0;
      tv_cnt = 0;
      div_s_tready = 1'b0;
      div_u_tready = 1'b0;
    end else begin
      if (cd > 0) begin
        cd = cd - 1;
        if (cd == 0) begin
          if (pend_u) begin
            div_u_dout = pend_res;
            div_u_dout_tvalid = 1'b1;
          end else begin
            div_s_dout = pend_res;
            div_s_dout_tvalid = 1'b1;
          end
        end
      end
      div_s_tready = 1'b0;
      div_u_tready = 1'b0;
      if (div_s_tvalid || div_u_tvalid) begin
        tv_cnt = tv_cnt + 1;
        if (tv_cnt > ip_rdy) begin
          if (cd != 0 || (div_s_tvalid && div_u_tvalid)) ip_overlap_err = 1'b1;
          pend_u = div_u_tvalid;
          pend_res = ref_div(pend_u, div_dividend, div_divisor);
          cd = ip_lat;
          tv_cnt = 0;
          if (pend_u) div_u_tready = 1'b1;
          else div_s_tready = 1'b1;
        end
      end else begin
        tv_cnt = 0;
      end
    end
  end

  task automatic step();
    @(negedge clk);
    #1;
  endtask

  task automatic set_idle();
    es_valid = 0; es_leave = 0; es_ex = 0; flush = 0;
    op_div = 0; op_divu = 0; op_mult = 0; op_multu = 0; op_mthi = 0; op_mtlo = 0;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    set_idle();
    step();
    step();
    reset = 1'b0;
  endtask

  task automatic do_div(input string nm, input bit u, input logic [DW-1:0] a, input logic [DW-1:0] b,
                        input int lat, input int rdy, input int hold, input bit ex, input bit from_idle,
                        input bit chain, output logic [DW-1:0] h_obs, output logic [DW-1:0] l_obs,
                        output int tvc);
    logic [2*DW-1:0] exp_r;
    logic [1:0] exp_we;
    int stall, first_tv, writes, n;
    bit done;
    exp_r = ref_div(u, a, b);
    ip_lat = lat;
    ip_rdy = rdy;
    stall = 0; first_tv = -1; writes = 0; n = 0; done = 0; tvc = 0;
    h_obs = '0; l_obs = '0;
    while (!done && n < 300) begin
      step();
      es_valid = 1; op_div = ~u; op_divu = u; es_ex = ex; flush = 0; es_leave = 0;
      src1 = (from_idle && n > 0) ? DW'($urandom) : a;
      src2 = (from_idle && n > 0) ? DW'($urandom) : b;
      #1;
      if (es_stop === 1'b1) begin
        stall++;
        n_tests++;
        if (hl_we !== 2'b00 || (u ? div_s_tvalid : div_u_tvalid) !== 1'b0) begin
          n_fail++;
          $display("FAIL %s stall_quiet: hl_we=%b wrong_tvalid=%b, required 00/0", nm, hl_we,
                   u ? div_s_tvalid : div_u_tvalid);
        end
        if ((u ? div_u_tvalid : div_s_tvalid) === 1'b1) begin
          tvc++;
          if (first_tv < 0) first_tv = n;
          n_tests++;
          if (div_dividend !== a || div_divisor !== b) begin
            n_fail++;
            $display("FAIL %s operands: got %h/%h, required %h/%h", nm, div_dividend, div_divisor, a, b);
          end
        end
      end else begin
        done = 1;
      end
      n++;
    end
    n_tests++;
    if (!done) begin
      n_fail++;
      $display("FAIL %s timeout: es_stop still %b after %0d cycles, required 0", nm, es_stop, n);
      do_reset();
      return;
    end
    for (int k = 0; k <= hold; k++) begin
      if (k > 0) begin
        step();
        es_valid = 1; op_div = ~u; op_divu = u; es_ex = ex;
      end
      es_leave = (k == hold);
      #1;
      exp_we = (k == 0 && !ex) ? 2'b11 : 2'b00;
      n_tests++;
      if (hl_we !== exp_we || es_stop !== 1'b0) begin
        n_fail++;
        $display("FAIL %s done_cycle%0d: hl_we=%b es_stop=%b, required %b/0", nm, k, hl_we, es_stop, exp_we);
      end
      if (hl_we === 2'b11) begin
        writes++;
        h_obs = h_wdata;
        l_obs = l_wdata;
        n_tests++;
        if ({l_wdata, h_wdata} !== exp_r) begin
          n_fail++;
          $display("FAIL %s result: got lo=%h hi=%h, required lo=%h hi=%h", nm, l_wdata, h_wdata,
                   exp_r[2*DW-1:DW], exp_r[DW-1:0]);
        end
      end
    end
    n_tests++;
    if (writes != (ex ? 0 : 1)) begin
      n_fail++;
      $display("FAIL %s write_count: got %0d, required %0d", nm, writes, ex ? 0 : 1);
    end
    n_tests++;
    if (tvc != rdy + 1) begin
      n_fail++;
      $display("FAIL %s tvalid_len: got %0d, required %0d", nm, tvc, rdy + 1);
    end
    if (from_idle) begin
      n_tests++;
      if (first_tv != 1 || stall != lat + rdy + 2) begin
        n_fail++;
        $display("FAIL %s timing: first_tvalid=%0d stall=%0d, required 1/%0d", nm, first_tv, stall, lat + rdy + 2);
      end
    end
    n_tests++;
    if (ip_overlap_err) begin
      n_fail++;
      $display("FAIL %s ip_overlap: issued while a result was pending, got 1 required 0", nm);
      ip_overlap_err = 0;
    end
    if (!chain) begin
      step();
      set_idle();
    end
  endtask

  task automatic test_reset();
    do_reset();
    reset = 1'b1;
    step();
    n_tests++;
    if ({div_s_tvalid, div_u_tvalid, es_stop, hl_we, div_dividend, div_divisor, h_wdata, l_wdata} !== '0) begin
      n_fail++;
      $display("FAIL reset_outputs: got tv=%b%b stop=%b we=%b dd=%h dv=%h h=%h l=%h, required all 0",
               div_s_tvalid, div_u_tvalid, es_stop, hl_we, div_dividend, div_divisor, h_wdata, l_wdata);
    end
    reset = 1'b0;
  endtask

  task automatic test_div_signed();
    logic [DW-1:0] h, l;
    int tvc;
    do_div("div_signed", 0, 32'hFFFF_FFF9, 32'd2, 20, 0, 0, 0, 1, 0, h, l, tvc);
    n_tests++;
    if (h !== 32'hFFFF_FFFF || l !== 32'hFFFF_FFFD) begin
      n_fail++;
      $display("FAIL div_signed_const: got hi=%h lo=%h, required hi=ffffffff lo=fffffffd", h, l);
    end
  endtask

  task automatic test_divu_backpressure();
    logic [DW-1:0] h, l;
    int tvc;
    do_div("divu_bp", 1, 32'hFFFF_FFFF, 32'h10, 5, 3, 0, 0, 1, 0, h, l, tvc);
    n_tests++;
    if (h !== 32'h0000_000F || l !== 32'h0FFF_FFFF || tvc != 4) begin
      n_fail++;
      $display("FAIL divu_bp_const: got hi=%h lo=%h tvalid=%0d, required hi=f lo=0fffffff tvalid=4", h, l, tvc);
    end
  endtask

  task automatic test_done_hold();
    logic [DW-1:0] h, l;
    int tvc;
    do_div("done_hold", 0, 32'd100, 32'd7, 3, 1, 5, 0, 1, 0, h, l, tvc);
    do_div("done_ex", 1, 32'd55, 32'd5, 2, 0, 2, 1, 1, 0, h, l, tvc);
  endtask

  task automatic test_flush_drain();
    logic [DW-1:0] h, l;
    int tvc, k;
    bit seen;
    ip_lat = 15; ip_rdy = 0; seen = 0; k = 0;
    for (int n = 0; n < 12 && k < 3; n++) begin
      step();
      es_valid = 1; op_div = 1; src1 = 32'd50; src2 = 32'd3;
      #1;
      if (div_s_tvalid === 1'b1) seen = 1;
      else if (seen) k++;
    end
    step();
    flush = 1;
    #1;
    n_tests++;
    if (hl_we !== 2'b00) begin
      n_fail++;
      $display("FAIL flush_wait_we: got %b, required 00", hl_we);
    end
    step();
    set_idle();
    #1;
    n_tests++;
    if (es_stop !== 1'b0 || hl_we !== 2'b00 || div_s_tvalid !== 1'b0) begin
      n_fail++;
      $display("FAIL flush_drain_quiet: stop=%b we=%b tv=%b, required 0/00/0", es_stop, hl_we, div_s_tvalid);
    end
    do_div("after_drain", 0, 32'd1000, 32'hFFFF_FFF7, 4, 0, 0, 0, 0, 0, h, l, tvc);
  endtask

  task automatic test_flush_issue();
    logic [DW-1:0] h, l;
    int tvc;
    ip_lat = 5; ip_rdy = 3;
    step();
    es_valid = 1; op_div = 1; src1 = 32'd77; src2 = 32'd7;
    for (int n = 1; n <= 5; n++) begin
      step();
      es_valid = (n <= 2); op_div = (n <= 2); flush = (n == 2);
      #1;
      n_tests++;
      if (div_s_tvalid !== (n <= 4) || hl_we !== 2'b00) begin
        n_fail++;
        $display("FAIL flush_issue_c%0d: tvalid=%b we=%b, required %b/00", n, div_s_tvalid, hl_we, n <= 4);
      end
    end
    set_idle();
    do_div("after_issue_flush", 1, 32'd900, 32'd11, 3, 0, 0, 0, 0, 0, h, l, tvc);
  endtask

  task automatic test_wait_flush_dout();
    logic [DW-1:0] h, l;
    int tvc;
    bit got;
    ip_lat = 6; ip_rdy = 0; got = 0;
    for (int n = 0; n < 40 && !got; n++) begin
      step();
      es_valid = 1; op_div = 1; flush = 0; src1 = 32'd31; src2 = 32'd4;
      if (div_s_dout_tvalid === 1'b1) begin
        flush = 1;
        got = 1;
        #1;
        n_tests++;
        if (hl_we !== 2'b00) begin
          n_fail++;
          $display("FAIL wait_flush_dout_we: got %b, required 00", hl_we);
        end
      end
    end
    n_tests++;
    if (!got) begin
      n_fail++;
      $display("FAIL wait_flush_dout_seen: got 0, required 1");
    end
    step();
    set_idle();
    do_div("after_flush_dout", 0, 32'hFFFF_FF00, 32'd16, 3, 1, 0, 0, 1, 0, h, l, tvc);
  endtask

  task automatic test_mult();
    logic [DW-1:0] v;
    prod = 64'h0000_0001_8000_0000;
    for (int n = 0; n <= 2; n++) begin
      step();
      set_idle();
      es_valid = 1; op_mult = 1; es_leave = (n == 2);
      #1;
      n_tests++;
      if (hl_we !== ((n == 2) ? 2'b11 : 2'b00) || es_stop !== 1'b0 ||
          (n == 2 && (h_wdata !== 32'h1 || l_wdata !== 32'h8000_0000))) begin
        n_fail++;
        $display("FAIL mult_c%0d: we=%b h=%h l=%h stop=%b, required %b h=1 l=80000000 stop=0", n, hl_we,
                 h_wdata, l_wdata, es_stop, (n == 2) ? 2'b11 : 2'b00);
      end
    end
    v = $urandom;
    for (int n = 0; n < 3; n++) begin
      step();
      set_idle();
      es_valid = 1; es_leave = 1; src1 = v;
      op_mthi = (n < 2); op_mtlo = (n == 2); es_ex = (n == 0);
      #1;
      n_tests++;
      case (n)
        0: if (hl_we !== 2'b00) begin
             n_fail++; $display("FAIL mthi_ex: we=%b, required 00", hl_we);
           end
        1: if (hl_we !== 2'b10 || h_wdata !== v) begin
             n_fail++; $display("FAIL mthi: we=%b h=%h, required 10 h=%h", hl_we, h_wdata, v);
           end
        default: if (hl_we !== 2'b01 || l_wdata !== v) begin
             n_fail++; $display("FAIL mtlo: we=%b l=%h, required 01 l=%h", hl_we, l_wdata, v);
           end
      endcase
    end
    step();
    set_idle();
  endtask

  task automatic test_random_alu();
    int op, d;
    bit ex, fl;
    logic [1:0] exp_we;
    logic [DW-1:0] exp_h, exp_l;
    for (int it = 0; it < 40; it++) begin
      op = $urandom_range(0, 3);
      ex = ($urandom_range(0, 4) == 0);
      fl = ($urandom_range(0, 5) == 0);
      d = $urandom_range(0, 2);
      prod = {32'($urandom), 32'($urandom)};
      for (int n = 0; n <= d; n++) begin
        step();
        set_idle();
        src1 = $urandom;
        es_valid = 1; es_ex = ex; es_leave = (n == d); flush = (n == d) && fl;
        op_mult = (op == 0); op_multu = (op == 1); op_mthi = (op == 2); op_mtlo = (op == 3);
        exp_we = (n < d || ex || fl) ? 2'b00 : (op < 2) ? 2'b11 : (op == 2) ? 2'b10 : 2'b01;
        exp_h = (op < 2) ? prod[2*DW-1:DW] : src1;
        exp_l = (op < 2) ? prod[DW-1:0] : src1;
        #1;
        n_tests++;
        if (hl_we !== exp_we || es_stop !== 1'b0 || (exp_we[1] && h_wdata !== exp_h) ||
            (exp_we[0] && l_wdata !== exp_l)) begin
          n_fail++;
          $display("FAIL rand_alu it%0d op%0d: we=%b h=%h l=%h, required we=%b h=%h l=%h", it, op, hl_we,
                   h_wdata, l_wdata, exp_we, exp_h, exp_l);
        end
      end
    end
    step();
    set_idle();
  endtask

  task automatic test_back_to_back();
    logic [DW-1:0] h, l;
    int tvc;
    do_div("b2b_0", 0, 32'd12345, 32'd10, 2, 0, 0, 0, 1, 1, h, l, tvc);
    do_div("b2b_1", 1, 32'd99, 32'd9, 1, 2, 0, 0, 1, 1, h, l, tvc);
    do_div("b2b_2", 0, 32'h8000_0001, 32'd3, 4, 1, 1, 0, 1, 0, h, l, tvc);
  endtask

  task automatic test_random_div();
    logic [DW-1:0] a, b, h, l;
    int tvc;
    bit u;
    for (int it = 0; it < 20; it++) begin
      u = $urandom_range(0, 1);
      a = $urandom;
      b = $urandom_range(0, 1) ? DW'($urandom) : DW'($urandom_range(1, 20));
      if ($urandom_range(0, 3) == 0) b = -b;
      if (b == 0) b = 1;
      if (!u && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) b = 3;
      do_div("rand_div", u, a, b, $urandom_range(1, 12), $urandom_range(0, 3), $urandom_range(0, 3),
             ($urandom_range(0, 9) == 0), 1, $urandom_range(0, 1), h, l, tvc);
    end
    step();
    set_idle();
  endtask

  task automatic test_reset_mid();
    logic [DW-1:0] h, l;
    int tvc;
    ip_lat = 4; ip_rdy = 5;
    step();
    es_valid = 1; op_div = 1; src1 = 32'd123; src2 = 32'd4;
    step();
    n_tests++;
    if (div_s_tvalid !== 1'b1) begin
      n_fail++;
      $display("FAIL reset_mid_issue: tvalid=%b, required 1", div_s_tvalid);
    end
    step();
    set_idle();
    reset = 1'b1;
    step();
    n_tests++;
    if ({div_s_tvalid, div_u_tvalid, es_stop, hl_we, div_dividend, div_divisor, h_wdata, l_wdata} !== '0) begin
      n_fail++;
      $display("FAIL reset_mid_outputs: tv=%b%b stop=%b we=%b dd=%h dv=%h, required all 0",
               div_s_tvalid, div_u_tvalid, es_stop, hl_we, div_dividend, div_divisor);
    end
    reset = 1'b0;
    do_div("after_reset", 1, 32'd4000, 32'd33, 2, 1, 0, 0, 1, 0, h, l, tvc);
  endtask

  initial begin
    test_reset();
    test_div_signed();
    test_divu_backpressure();
    test_done_hold();
    test_flush_drain();
    test_flush_issue();
    test_wait_flush_dout();
    test_mult();
    test_random_alu();
    test_back_to_back();
    test_random_div();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
